pila_dir: RTL and testbench

- Hardware return-address stack: the responder to the control unit's push/pop/s_pila signals.
- Sits beside the PC path.
- On push it stores the address from the PC datapath (PC+1).
- On pop it presents the stored address on dout so the PC mux can load it when s_pila=1.
- Provides full/empty status and sticky error flags for debug and trap logic.

---
 rtl/pila_dir_if.sv | 40 ++++
 rtl/pila_dir.sv | 101 ++++++++++
 tb/tb_pila_dir.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/pila_dir_if.sv
// pila_dir_if: bundle between the control unit (master) and the return-address
// stack (slave).
//
// Signals:
//   push, pop, clr_err, din      master -> slave commands and data
//   dout, empty, full, level     slave -> master stack contents and status
//   ovf, udf                     slave -> master sticky error flags
//
// Handshake semantics: this bundle has no valid/ready pair. push and pop are
// single-cycle commands that the stack always takes on the rising edge where
// they are high. A command that cannot be honoured is dropped, and the drop
// is recorded in ovf (push while full) or udf (pop while empty). The value
// that a pop consumes is the dout present during the cycle in which pop is high.
interface pila_dir_if #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
);
    localparam int AW = $clog2(DEPTH);

    logic             push;
    logic             pop;
    logic             clr_err;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             empty;
    logic             full;
    logic [AW:0]      level;
    logic             ovf;
    logic             udf;

    modport master (
        output push, pop, clr_err, din,
        input  dout, empty, full, level, ovf, udf
    );

    modport slave (
        input  push, pop, clr_err, din,
        output dout, empty, full, level, ovf, udf
    );
endinterface

// File: rtl/pila_dir.sv
// pila_dir: hardware return-address stack placed beside the PC path.
// A push stores the return address (PC+1). dout always presents the current
// top of stack, so the PC mux can load dout in the same cycle that pop is high.
//
// Ports:
//   clk    system clock; all state changes happen on its rising edge
//   reset  asynchronous reset, active-low
//   bus    pila_dir_if.slave (push/pop/clr_err/din in; dout/empty/full/level/ovf/udf out)
//
// This block has no FSM. Its only state is the stack pointer sp (equal to
// level), the registered top of stack, and the two sticky flags.
module pila_dir #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input logic       clk,
    input logic       reset,
    pila_dir_if.slave bus
);
    localparam logic [AW:0] SP_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] SP_ONE  = (AW+1)'(1);
    localparam logic [AW:0] SP_TWO  = (AW+1)'(2);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      sp;
    logic [WIDTH-1:0] dout_q;
    logic             ovf_q;
    logic             udf_q;

    logic             is_empty;
    logic             is_full;
    logic             do_push;
    logic             do_replace;
    logic             do_pop;
    logic             ovf_evt;
    logic             udf_evt;
    logic             wr_en;
    logic [AW:0]      sp_m1;
    logic [AW:0]      sp_m2;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;

    always_comb begin
        is_empty   = (sp == '0);
        is_full    = (sp == SP_FULL);
        sp_m1      = sp - SP_ONE;
        sp_m2      = sp - SP_TWO;
        // Push+pop on a non-empty stack overwrites the top and leaves sp
        // unchanged. On an empty stack, push+pop acts as a plain push.
        do_replace = bus.push & bus.pop & ~is_empty;
        do_push    = bus.push & ~do_replace & ~is_full;
        ovf_evt    = bus.push & ~do_replace & is_full;
        do_pop     = bus.pop & ~bus.push & ~is_empty;
        udf_evt    = bus.pop & ~bus.push & is_empty;
        wr_en      = do_push | do_replace;
        wr_idx     = do_replace ? sp_m1[AW-1:0] : sp[AW-1:0];
        // Entry that becomes the new top after a pop; used only when sp >= 2.
        rd_idx     = sp_m2[AW-1:0];
    end

    // The storage array has no reset. Reads only ever target indices below
    // sp, so an unwritten entry can never reach dout.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= bus.din;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sp     <= '0;
            dout_q <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else begin
            if (do_push) begin
                sp <= sp + SP_ONE;
            end else if (do_pop) begin
                sp <= sp_m1;
            end

            if (wr_en) begin
                dout_q <= bus.din;
            end else if (do_pop) begin
                dout_q <= (sp >= SP_TWO) ? mem[rd_idx] : '0;
            end

            // A new error on the same edge as clr_err wins over the clear.
            ovf_q <= (ovf_q & ~bus.clr_err) | ovf_evt;
            udf_q <= (udf_q & ~bus.clr_err) | udf_evt;
        end
    end

    assign bus.dout  = dout_q;
    assign bus.level = sp;
    assign bus.empty = is_empty;
    assign bus.full  = is_full;
    assign bus.ovf   = ovf_q;
    assign bus.udf   = udf_q;
endmodule

// File: tb/tb_pila_dir.sv
module tb_pila_dir;
    localparam int WIDTH = 10;
    localparam int DEPTH = 8;

    logic clk;
    logic reset;

    pila_dir_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    pila_dir #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard / reference model ----------------
    // exp_q holds the stack contents, bottom first. The top is the last element.
    logic [WIDTH-1:0] exp_q[$];
    logic             exp_ovf;
    logic             exp_udf;
    int               total;
    int               bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_ovf = 1'b0;
        exp_udf = 1'b0;
    endtask

    task automatic model_step(input logic p, input logic q, input logic [WIDTH-1:0] d,
                              input logic c);
        logic o_evt;
        logic u_evt;
        o_evt = 1'b0;
        u_evt = 1'b0;
        if (p && q && exp_q.size() != 0) begin
            exp_q[exp_q.size()-1] = d;
        end else if (p) begin
            if (exp_q.size() == DEPTH) o_evt = 1'b1;
            else exp_q.push_back(d);
        end else if (q) begin
            if (exp_q.size() == 0) u_evt = 1'b1;
            else void'(exp_q.pop_back());
        end
        exp_ovf = (exp_ovf && !c) || o_evt;
        exp_udf = (exp_udf && !c) || u_evt;
    endtask

    function automatic logic [WIDTH-1:0] exp_top();
        return (exp_q.size() == 0) ? '0 : exp_q[exp_q.size()-1];
    endfunction

    task automatic check_all(input string tag);
        chk({tag, "_dout"},  bus.dout,  exp_top());
        chk({tag, "_level"}, bus.level, exp_q.size());
        chk({tag, "_empty"}, bus.empty, exp_q.size() == 0);
        chk({tag, "_full"},  bus.full,  exp_q.size() == DEPTH);
        chk({tag, "_ovf"},   bus.ovf,   exp_ovf);
        chk({tag, "_udf"},   bus.udf,   exp_udf);
    endtask

    // ---------------- driver ----------------
    // Inputs change 1 time unit after a rising edge. Outputs are sampled
    // 1 time unit after the same edge.
    task automatic cyc(input string tag, input logic p, input logic q,
                       input logic [WIDTH-1:0] d, input logic c);
        bus.push    = p;
        bus.pop     = q;
        bus.din     = d;
        bus.clr_err = c;
        #1;
        // The value consumed by a pop is the dout seen in the pop cycle.
        if (q && !p && exp_q.size() != 0) chk({tag, "_popread"}, bus.dout, exp_top());
        @(posedge clk);
        #1;
        model_step(p, q, d, c);
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.din     = '0;
        bus.clr_err = 1'b0;
        check_all(tag);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        total       = 0;
        bad         = 0;
        reset       = 1'b0;
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.din     = '0;
        bus.clr_err = 1'b0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout",  bus.dout,  10'h000);
        chk("rst_level", bus.level, 0);
        chk("rst_empty", bus.empty, 1);
        chk("rst_full",  bus.full,  0);
        chk("rst_ovf",   bus.ovf,   0);
        chk("rst_udf",   bus.udf,   0);
        reset = 1'b1;

        // Three pushes, then three pops in LIFO order.
        cyc("push1", 1'b1, 1'b0, 10'h005, 1'b0);
        chk("push1_const", bus.dout, 10'h005);
        cyc("push2", 1'b1, 1'b0, 10'h00A, 1'b0);
        chk("push2_const", bus.dout, 10'h00A);
        cyc("push3", 1'b1, 1'b0, 10'h00F, 1'b0);
        chk("push3_const", bus.dout, 10'h00F);
        chk("push3_level", bus.level, 3);
        chk("push3_empty", bus.empty, 0);
        cyc("pop1", 1'b0, 1'b1, '0, 1'b0);
        chk("pop1_const", bus.dout, 10'h00A);
        cyc("pop2", 1'b0, 1'b1, '0, 1'b0);
        chk("pop2_const", bus.dout, 10'h005);
        cyc("pop3", 1'b0, 1'b1, '0, 1'b0);
        chk("pop3_dout",  bus.dout,  10'h000);
        chk("pop3_empty", bus.empty, 1);
        chk("pop3_udf",   bus.udf,   0);

        // Fill to DEPTH, then an overflowing push of 3FF.
        for (int i = 0; i < DEPTH; i++) cyc("fill", 1'b1, 1'b0, 10'(10'h100 + i), 1'b0);
        cyc("ovf_push", 1'b1, 1'b0, 10'h3FF, 1'b0);
        chk("ovf_full",  bus.full,  1);
        chk("ovf_level", bus.level, DEPTH);
        chk("ovf_flag",  bus.ovf,   1);
        chk("ovf_dout",  bus.dout,  10'h107);
        for (int i = 0; i < DEPTH; i++) cyc("drain", 1'b0, 1'b1, '0, 1'b0);
        chk("drain_empty", bus.empty, 1);

        // Replace the top with a simultaneous push and pop.
        cyc("rp_a", 1'b1, 1'b0, 10'h010, 1'b0);
        cyc("rp_b", 1'b1, 1'b0, 10'h020, 1'b0);
        cyc("rp_both", 1'b1, 1'b1, 10'h111, 1'b0);
        chk("rp_level", bus.level, 2);
        chk("rp_dout",  bus.dout,  10'h111);
        cyc("rp_pop", 1'b0, 1'b1, '0, 1'b0);
        chk("rp_first", bus.dout, 10'h010);
        cyc("rp_pop2", 1'b0, 1'b1, '0, 1'b0);

        // Underflow, clear, and a new underflow on the same edge as the clear.
        cyc("udf_pop", 1'b0, 1'b1, '0, 1'b0);
        chk("udf_flag",  bus.udf,   1);
        chk("udf_level", bus.level, 0);
        cyc("udf_clr", 1'b0, 1'b0, '0, 1'b1);
        chk("udf_cleared", bus.udf, 0);
        chk("ovf_cleared", bus.ovf, 0);
        cyc("udf_clrpop", 1'b0, 1'b1, '0, 1'b1);
        chk("udf_wins", bus.udf, 1);

        // Asynchronous reset asserted between clock edges.
        for (int i = 0; i < 4; i++) cyc("pre_rst", 1'b1, 1'b0, 10'(10'h301 + i), 1'b0);
        #3;
        reset = 1'b0;
        #1;
        model_reset();
        chk("arst_level", bus.level, 0);
        chk("arst_dout",  bus.dout,  10'h000);
        chk("arst_empty", bus.empty, 1);
        chk("arst_ovf",   bus.ovf,   0);
        chk("arst_udf",   bus.udf,   0);
        #2;
        reset = 1'b1;
        cyc("post_rst", 1'b1, 1'b0, 10'h077, 1'b0);
        chk("post_rst_dout",  bus.dout,  10'h077);
        chk("post_rst_level", bus.level, 1);

        // Random traffic: a push-heavy phase, then a pop-heavy phase, so both
        // the full and the empty boundaries are reached.
        for (int i = 0; i < 400; i++) begin
            logic p;
            logic q;
            logic c;
            int   bias;
            bias = (i < 200) ? 65 : 30;
            p = ($urandom_range(0, 99) < bias);
            q = ($urandom_range(0, 99) < (100 - bias));
            c = ($urandom_range(0, 15) == 0);
            cyc("rand", p, q, 10'($urandom_range(0, 1023)), c);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
